pattern_recognizer_prog: RTL
============================

// Module: pattern_recognizer_prog
// PURPOSE
//  Runtime-programmable serial pattern detector. Successor to the fixed 4-bit Moore recognizer.
//  Adds the following:
//  - pattern and length loaded at runtime (1..MAX_LEN bits)
//  - selectable overlapping / non-overlapping detection
//  - input qualifier and saturating match counter
//  Sits on a serial bit stream behind a link/deserializer. seen is a registered (Moore) strobe.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of match_count
// PORTS
//  clk          in   1                   rising-edge clock
//  reset        in   1                   async, active-high; clears all state
//  bit_in       in   1                   serial data bit
//  bit_valid    in   1                   bit_in accepted on this edge when 1
//  cfg_load     in   1                   latch cfg_* and restart detection
//  cfg_pattern  in   MAX_LEN             pattern; bit [len-1] = first bit received
//  cfg_len      in   $clog2(MAX_LEN+1)   pattern length
//  cfg_overlap  in   1                   1 = overlapping matches allowed
//  count_clr    in   1                   synchronous clear of match_count
//  seen         out  1                   1-cycle pulse after completing bit accepted
//  match_count  out  CNT_W               matches since reset/clr, saturating
//  armed        out  1                   1 when state != UNCFG
// BEHAVIOUR
//  Reset
//  - Reset is asynchronous, active-high; clock is clk.
//  - On reset: state=UNCFG, hist=0, fill=0, pattern=0, len=0, overlap=0.
//  - All outputs are 0 after reset.
//  Registers
//  - hist[MAX_LEN-1:0]: bit history.
//  - fill: count of valid bits since the last restart, saturating at MAX_LEN.
//  - Latched pattern, len and overlap.
//  FSM states: UNCFG, FILL, RUN
//  - UNCFG: bits are ignored. cfg_load with len>=1 -> FILL. cfg_load with len==0 -> stays UNCFG.
//  - FILL: fill<len. Each valid bit: hist<={hist[MAX_LEN-2:0],bit_in}, fill++.
//    -> RUN when the accepted bit makes fill==len.
//  - RUN: hist window holds >= len valid bits.
//  Length clamp: cfg_len > MAX_LEN is clamped to MAX_LEN at load.
//  Match condition
//  - A match is an accepted bit where hist_next[len-1:0]==pattern[len-1:0] and fill_next>=len.
//  - On match, seen=1 in the next cycle, for exactly one cycle.
//  - Latency: 1 clock from the accepting edge.
//  - For len=1, every matching valid bit produces a pulse; back-to-back pulses are legal.
//  After a match
//  - overlap=1: stay in RUN; the history is kept.
//  - overlap=0: hist<=0, fill<=0, state->FILL. The next match needs len fresh bits.
//  bit_valid=0: hist, fill and state hold; seen is 0 for that cycle.
//  cfg_load has priority over bit_valid in the same cycle.
//  - The bit is dropped.
//  - hist and fill are cleared; state -> FILL, or UNCFG if len==0.
//  - seen is 0 the next cycle.
//  - match_count is unchanged.
//  match_count
//  - Increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
//  - count_clr wins over a same-cycle match: the result is 0.
//  Reset mid-stream: a pending seen pulse is squashed and the config is lost; armed drops immediately.
//  Register usage: pattern and overlap are used only in their latched form; cfg_* may change freely
//  while cfg_load=0.
// TESTING
//  1. Overlapping stream: load 1011, len=4, overlap=1; stream 1011011 -> seen after bits 4 and 7;
//     match_count=2.
//  2. Non-overlapping stream: same load with overlap=0; stream 1011011 -> seen after bit 4 only;
//     match_count=1.
//  3. bit_valid gaps: stream 1,0,1,1 with 3 idle cycles between each bit -> single seen, 1 clk
//     after the 4th valid edge.
//  4. Counter saturation: CNT_W=2, len=1, pattern=1; six 1s -> match_count saturates at 3;
//     count_clr with a same-cycle match -> 0.
//  5. Mid-stream reload: after 101, cfg_load 11 len=2 with bit_valid=1 -> bit dropped; then 1,1
//     -> seen; len=0 load -> armed=0, no seen on any input.
//  6. Async reset mid-match: assert reset between the completing edge and the seen cycle ->
//     seen stays 0; all outputs 0; armed=0.

Source files
------------

// File: rtl/pattern_recognizer_prog.sv
// pattern_recognizer_prog: serial pattern detector whose pattern, length and
// overlap mode are loaded at run time. seen is a registered one-cycle strobe
// that follows the accepting edge. match_count saturates instead of wrapping.
module pattern_recognizer_prog #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         bit_in,
   input  logic                         bit_valid,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         count_clr,
   output logic                         seen,
   output logic [CNT_W-1:0]             match_count,
   output logic                         armed
);

   localparam int LEN_W = $clog2(MAX_LEN+1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   typedef enum logic [1:0] {UNCFG, FILL, RUN} state_t;

   state_t             state;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic               overlap;

   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_next;
   logic [LEN_W-1:0]   len_clamped;
   logic               window_eq;
   logic               accept;
   logic               match;

   // Next history/fill for an accepted bit and the resulting match decision
   always_comb begin
      hist_next   = {hist[MAX_LEN-2:0], bit_in};
      fill_next   = (fill == LEN_MAX) ? fill : fill + 1'b1;
      len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      window_eq   = 1'b1;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (i < 32'(len) && hist_next[i] != pattern[i]) begin
            window_eq = 1'b0;
         end
      end
      // cfg_load takes the cycle, so a bit presented alongside it is dropped
      accept = bit_valid && !cfg_load && (state != UNCFG);
      match  = accept && window_eq && (fill_next >= len);
   end

   // Configuration, detection FSM, seen strobe and saturating match counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= UNCFG;
         hist        <= '0;
         fill        <= '0;
         pattern     <= '0;
         len         <= '0;
         overlap     <= 1'b0;
         seen        <= 1'b0;
         match_count <= '0;
      end else begin
         seen <= match;

         if (count_clr) begin
            match_count <= '0;
         end else if (match && match_count != '1) begin
            match_count <= match_count + 1'b1;
         end

         if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            state   <= (cfg_len == '0) ? UNCFG : FILL;
         end else if (accept) begin
            if (match && !overlap) begin
               // Non-overlapping: the next match must be built from fresh bits
               hist  <= '0;
               fill  <= '0;
               state <= FILL;
            end else begin
               hist <= hist_next;
               fill <= fill_next;
               if (fill_next >= len) begin
                  state <= RUN;
               end
            end
         end
      end
   end

   assign armed = (state != UNCFG);

endmodule
